// File: rtl/sqrt_unit.sv
// Sequential truncating square root for the decimal floating format.
// Operand is scaled by 10^K to an even exponent, then rooted one bit per cycle.
module sqrt_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        eval,
    input  logic        signA,
    input  logic [33:0] mantA,
    input  logic [6:0]  expA,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        signRes,
    output logic [33:0] mantRes,
    output logic [6:0]  expRes
);

    typedef enum logic [1:0] {IDLE, SCALE, ROOT} state_t;

    state_t      state;
    state_t      stateNext;
    logic [67:0] radicand;
    logic [35:0] rem;
    logic [33:0] root;
    logic [5:0]  cnt;
    logic [6:0]  expHold;
    logic        special;
    logic        specialErr;

    logic [5:0]  kCycles;
    logic [7:0]  expDiff;
    logic [36:0] cand;
    logic [36:0] trial;
    logic [36:0] diff;
    logic        fits;
    logic [33:0] rootNext;
    logic [35:0] remNext;
    logic        isSpecial;

    always_comb begin
        kCycles   = expA[0] ? 6'd9 : 6'd10;
        expDiff   = {expA[6], expA} - {2'b00, kCycles};
        isSpecial = (mantA == 34'd0) || signA;
        // remainder never exceeds 2*root, so 35 bits of it carry all the value
        cand      = {rem[34:0], radicand[67:66]};
        trial     = {1'b0, root, 2'b01};
        diff      = cand - trial;
        fits      = (cand >= trial);
        rootNext  = {root[32:0], fits};
        remNext   = fits ? diff[35:0] : cand[35:0];
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (eval)
                    stateNext = isSpecial ? ROOT : SCALE;
            end
            SCALE: begin
                if (cnt == 6'd0)
                    stateNext = ROOT;
            end
            ROOT: begin
                if (cnt == 6'd0)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            signRes    <= 1'b0;
            mantRes    <= 34'd0;
            expRes     <= 7'd0;
            radicand   <= 68'd0;
            rem        <= 36'd0;
            root       <= 34'd0;
            cnt        <= 6'd0;
            expHold    <= 7'd0;
            special    <= 1'b0;
            specialErr <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (eval) begin
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        special    <= isSpecial;
                        specialErr <= signA && (mantA != 34'd0);
                        radicand   <= {34'd0, mantA};
                        rem        <= 36'd0;
                        root       <= 34'd0;
                        expHold    <= expDiff[7:1];
                        // zero and negative operands finish on the next edge
                        cnt        <= isSpecial ? 6'd0 : kCycles - 6'd1;
                    end
                end
                SCALE: begin
                    radicand <= (radicand << 3) + (radicand << 1);
                    cnt      <= (cnt == 6'd0) ? 6'd33 : cnt - 6'd1;
                end
                ROOT: begin
                    radicand <= radicand << 2;
                    rem      <= remNext;
                    root     <= rootNext;
                    cnt      <= cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        signRes <= 1'b0;
                        if (special) begin
                            mantRes <= 34'd0;
                            expRes  <= 7'd0;
                            err     <= specialErr;
                        end else begin
                            mantRes <= rootNext;
                            expRes  <= expHold;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
